// File: rtl/bank_reg_ctrl_pkg.sv
// bank_reg_ctrl_pkg: shared state encodings, register map and default keys for the bank register controller.
package bank_reg_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_KEY1_OK  = 2'd1,
        ST_UNLOCKED = 2'd2
    } state_e;

    localparam logic [1:0] REG_KEY     = 2'd0;
    localparam logic [1:0] REG_BANK_LO = 2'd1;
    localparam logic [1:0] REG_BANK_HI = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    localparam int CTRL_COMMIT = 0;
    localparam int CTRL_RELOCK = 7;

    localparam logic [7:0] DEF_KEY1 = 8'h55;
    localparam logic [7:0] DEF_KEY2 = 8'hAA;
endpackage

// File: rtl/bank_reg_ctrl_if.sv
// bank_reg_ctrl_if: CPU write port and bank register outputs of the bank register controller.
interface bank_reg_ctrl_if #(
    parameter int BANK_WIDTH = 9
);
    logic                  we;
    logic [1:0]            addr;
    logic [7:0]            data_in;
    logic                  bank_en;
    logic [BANK_WIDTH-1:0] bank_d;
    logic                  locked;
    logic                  unlock_err;

    modport master (
        output we, addr, data_in,
        input  bank_en, bank_d, locked, unlock_err
    );

    modport slave (
        input  we, addr, data_in,
        output bank_en, bank_d, locked, unlock_err
    );
endinterface

// File: rtl/bank_reg_ctrl_key_timeout.sv
// key_timeout: counts idle cycles between the two unlock key bytes; expired flags the last allowed cycle.
module key_timeout #(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic run,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q;

    assign expired = cnt_q == CW'(TIMEOUT - 1);

    always_ff @(negedge clock) begin
        if (!reset_n || clear) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/bank_reg_ctrl.sv
// bank_reg_ctrl: key-guarded two-byte staging and single-pulse commit of the FLASH bank register.
// Optional BANK_AUTO_RELOCK_EN: every commit also relocks the controller.
module bank_reg_ctrl
    import bank_reg_ctrl_pkg::*;
#(
    parameter int         BANK_WIDTH = 9,
    parameter logic [7:0] KEY1       = DEF_KEY1,
    parameter logic [7:0] KEY2       = DEF_KEY2,
    parameter int         TIMEOUT    = 16,
    parameter int         RESET_BANK = 0
) (
    input logic           clock,
    input logic           reset_n,
    bank_reg_ctrl_if.slave bus
);
    state_e                state_q, state_d;
    logic [BANK_WIDTH-1:0] staged_q, staged_d;
    logic                  bank_en_q, bank_en_d;
    logic                  locked_q;
    logic                  err_q, err_d;
    logic                  expired, key_wr, commit, relock;

    assign key_wr = bus.we && bus.addr == REG_KEY;
    assign commit = bus.we && bus.addr == REG_CTRL && bus.data_in[CTRL_COMMIT];
    assign relock = bus.we && bus.addr == REG_CTRL && bus.data_in[CTRL_RELOCK];

    key_timeout #(.TIMEOUT(TIMEOUT)) u_key_timeout (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (state_q != ST_KEY1_OK),
        .run     (state_q == ST_KEY1_OK && !bus.we),
        .expired (expired)
    );

    always_comb begin
        state_d   = state_q;
        staged_d  = staged_q;
        err_d     = err_q;
        bank_en_d = 1'b0;
        case (state_q)
            ST_LOCKED: begin
                if (bus.we && !key_wr) err_d = 1'b1;
                if (key_wr && bus.data_in == KEY1) state_d = ST_KEY1_OK;
            end
            ST_KEY1_OK: begin
                // A write on the expiry cycle takes priority over the timeout.
                if (bus.we) begin
                    state_d = (key_wr && bus.data_in == KEY2) ? ST_UNLOCKED : ST_LOCKED;
                    err_d   = !(key_wr && bus.data_in == KEY2);
                end else if (expired) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_UNLOCKED: begin
                if (bus.we && bus.addr == REG_BANK_LO) staged_d[7:0] = bus.data_in;
                if (bus.we && bus.addr == REG_BANK_HI) staged_d[BANK_WIDTH-1:8] = bus.data_in[BANK_WIDTH-9:0];
                bank_en_d = commit;
`ifdef BANK_AUTO_RELOCK_EN
                if (relock || commit) state_d = ST_LOCKED;
`else
                if (relock) state_d = ST_LOCKED;
`endif
            end
            default: state_d = ST_LOCKED;
        endcase
    end

    always_ff @(negedge clock) begin
        if (!reset_n) begin
            state_q   <= ST_LOCKED;
            staged_q  <= BANK_WIDTH'(RESET_BANK);
            bank_en_q <= 1'b0;
            locked_q  <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            staged_q  <= staged_d;
            bank_en_q <= bank_en_d;
            locked_q  <= state_d != ST_UNLOCKED;
            err_q     <= err_d;
        end
    end

    assign bus.bank_en    = bank_en_q;
    assign bus.bank_d     = staged_q;
    assign bus.locked     = locked_q;
    assign bus.unlock_err = err_q;
endmodule

// File: tb/tb_bank_reg_ctrl.sv
// tb_bank_reg_ctrl: directed self-checking bench for bank_reg_ctrl; inputs change on rising edges, DUT acts on falling edges.
module tb_bank_reg_ctrl;
    logic clock;
    logic reset_n;
    int   checks;
    int   errors;
    int   en_cnt;
    logic [8:0] en_bank;
    logic en_locked;

    bank_reg_ctrl_if #(.BANK_WIDTH(9)) bus ();

    bank_reg_ctrl #(.BANK_WIDTH(9)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pulse monitor: records every rising-edge sample where bank_en is high.
    always @(posedge clock) begin
        if (bus.bank_en) begin
            en_cnt++;
            en_bank = bus.bank_d;
            en_locked = bus.locked;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic do_reset();
        reset_n = 1'b0;
        bus.we = 1'b0;
        bus.addr = 2'd0;
        bus.data_in = 8'h00;
        repeat (2) @(posedge clock);
        reset_n = 1'b1;
        en_cnt = 0;
    endtask

    task automatic write(input logic [1:0] a, input logic [7:0] d);
        bus.we = 1'b1;
        bus.addr = a;
        bus.data_in = d;
        @(posedge clock);
        bus.we = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
    endtask

    task automatic unlock();
        write(2'd0, 8'h55);
        write(2'd0, 8'hAA);
    endtask

    task automatic test_reset();
        do_reset();
        idle(1);
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL reset_locked: got %b want 1", bus.locked); end
        checks++; if (bus.unlock_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.unlock_err); end
        checks++; if (bus.bank_en !== 1'b0) begin errors++; $display("FAIL reset_bank_en: got %b want 0", bus.bank_en); end
        checks++; if (bus.bank_d !== 9'h000) begin errors++; $display("FAIL reset_bank_d: got %h want 000", bus.bank_d); end
    endtask

    task automatic test_commit();
        do_reset();
        unlock();
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL commit_unlocked: got %b want 0", bus.locked); end
        write(2'd1, 8'h34);
        write(2'd2, 8'h01);
        checks++; if (bus.bank_d !== 9'h134 || en_cnt !== 0) begin errors++; $display("FAIL commit_staged: got %h/%0d want 134/0", bus.bank_d, en_cnt); end
        write(2'd3, 8'h01);
        checks++; if (bus.bank_en !== 1'b1) begin errors++; $display("FAIL commit_pulse_on: got %b want 1", bus.bank_en); end
        idle(1);
        checks++; if (bus.bank_en !== 1'b0) begin errors++; $display("FAIL commit_pulse_off: got %b want 0", bus.bank_en); end
        idle(2);
        checks++; if (en_cnt !== 1) begin errors++; $display("FAIL commit_count: got %0d want 1", en_cnt); end
        checks++; if (en_bank !== 9'h134) begin errors++; $display("FAIL commit_bank: got %h want 134", en_bank); end
`ifdef BANK_AUTO_RELOCK_EN
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL commit_lock_state: got %b want 1", bus.locked); end
`else
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL commit_lock_state: got %b want 0", bus.locked); end
`endif
    endtask

    task automatic test_staging();
        do_reset();
        unlock();
        write(2'd1, 8'hAB);
        write(2'd2, 8'hFE);
        checks++; if (bus.bank_d !== 9'h0AB) begin errors++; $display("FAIL stage_hi_mask: got %h want 0ab", bus.bank_d); end
        write(2'd2, 8'h03);
        checks++; if (bus.bank_d !== 9'h1AB) begin errors++; $display("FAIL stage_hi_bit: got %h want 1ab", bus.bank_d); end
        write(2'd0, 8'h55);
        checks++; if (bus.locked !== 1'b0 || bus.unlock_err !== 1'b0) begin errors++; $display("FAIL stage_key_ignored: got %b/%b want 0/0", bus.locked, bus.unlock_err); end
        checks++; if (en_cnt !== 0) begin errors++; $display("FAIL stage_no_pulse: got %0d want 0", en_cnt); end
    endtask

    task automatic test_locked_write();
        do_reset();
        write(2'd1, 8'h12);
        idle(2);
        checks++; if (bus.unlock_err !== 1'b1) begin errors++; $display("FAIL locked_wr_err: got %b want 1", bus.unlock_err); end
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL locked_wr_locked: got %b want 1", bus.locked); end
        checks++; if (en_cnt !== 0 || bus.bank_d !== 9'h000) begin errors++; $display("FAIL locked_wr_bank: got %0d/%h want 0/000", en_cnt, bus.bank_d); end
        write(2'd0, 8'h55);
        checks++; if (bus.unlock_err !== 1'b1) begin errors++; $display("FAIL locked_key1_err: got %b want 1", bus.unlock_err); end
        write(2'd0, 8'hAA);
        checks++; if (bus.unlock_err !== 1'b0 || bus.locked !== 1'b0) begin errors++; $display("FAIL locked_unlock_clr: got %b/%b want 0/0", bus.unlock_err, bus.locked); end
        do_reset();
        write(2'd0, 8'h33);
        checks++; if (bus.unlock_err !== 1'b0 || bus.locked !== 1'b1) begin errors++; $display("FAIL locked_bad_key: got %b/%b want 0/1", bus.unlock_err, bus.locked); end
    endtask

    task automatic test_timeout();
        do_reset();
        write(2'd0, 8'h55);
        idle(16);
        write(2'd0, 8'hAA);
        checks++; if (bus.locked !== 1'b1 || bus.unlock_err !== 1'b0) begin errors++; $display("FAIL timeout_expire: got %b/%b want 1/0", bus.locked, bus.unlock_err); end
        do_reset();
        write(2'd0, 8'h55);
        idle(15);
        write(2'd0, 8'hAA);
        checks++; if (bus.locked !== 1'b0 || bus.unlock_err !== 1'b0) begin errors++; $display("FAIL timeout_write_wins: got %b/%b want 0/0", bus.locked, bus.unlock_err); end
    endtask

    task automatic test_bad_key2();
        do_reset();
        write(2'd0, 8'h55);
        write(2'd1, 8'h00);
        checks++; if (bus.locked !== 1'b1 || bus.unlock_err !== 1'b1) begin errors++; $display("FAIL bad_key2: got %b/%b want 1/1", bus.locked, bus.unlock_err); end
        checks++; if (bus.bank_d !== 9'h000) begin errors++; $display("FAIL bad_key2_discard: got %h want 000", bus.bank_d); end
    endtask

    task automatic test_relock();
        do_reset();
        unlock();
        write(2'd1, 8'h77);
        write(2'd3, 8'h81);
        idle(2);
        checks++; if (en_cnt !== 1 || en_locked !== 1'b1) begin errors++; $display("FAIL relock_pulse: got %0d/%b want 1/1", en_cnt, en_locked); end
        checks++; if (en_bank !== 9'h077) begin errors++; $display("FAIL relock_bank: got %h want 077", en_bank); end
        do_reset();
        unlock();
        write(2'd3, 8'h80);
        idle(1);
        checks++; if (bus.locked !== 1'b1 || en_cnt !== 0) begin errors++; $display("FAIL relock_only: got %b/%0d want 1/0", bus.locked, en_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        unlock();
        write(2'd3, 8'h01);
        write(2'd3, 8'h01);
        idle(2);
`ifdef BANK_AUTO_RELOCK_EN
        checks++; if (en_cnt !== 1 || bus.unlock_err !== 1'b1) begin errors++; $display("FAIL b2b_pulses: got %0d/%b want 1/1", en_cnt, bus.unlock_err); end
`else
        checks++; if (en_cnt !== 2 || bus.unlock_err !== 1'b0) begin errors++; $display("FAIL b2b_pulses: got %0d/%b want 2/0", en_cnt, bus.unlock_err); end
`endif
    endtask

    task automatic test_reset_commit();
        do_reset();
        unlock();
        write(2'd1, 8'h34);
        write(2'd2, 8'h01);
        reset_n = 1'b0;
        write(2'd3, 8'h01);
        reset_n = 1'b1;
        idle(1);
        checks++; if (en_cnt !== 0 || bus.bank_en !== 1'b0) begin errors++; $display("FAIL rst_commit_pulse: got %0d/%b want 0/0", en_cnt, bus.bank_en); end
        checks++; if (bus.bank_d !== 9'h000 || bus.locked !== 1'b1) begin errors++; $display("FAIL rst_commit_state: got %h/%b want 000/1", bus.bank_d, bus.locked); end
        do_reset();
        unlock();
        write(2'd1, 8'h34);
        write(2'd3, 8'h01);
        reset_n = 1'b0;
        idle(1);
        checks++; if (bus.bank_en !== 1'b0 || bus.bank_d !== 9'h000 || bus.locked !== 1'b1) begin errors++; $display("FAIL rst_during_pulse: got %b/%h/%b want 0/000/1", bus.bank_en, bus.bank_d, bus.locked); end
        checks++; if (en_cnt !== 1) begin errors++; $display("FAIL rst_during_count: got %0d want 1", en_cnt); end
        reset_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        en_cnt = 0;
        en_bank = '0;
        en_locked = 1'b0;
        reset_n = 1'b0;
        bus.we = 1'b0;
        bus.addr = 2'd0;
        bus.data_in = 8'h00;
        @(posedge clock);
        test_reset();
        test_commit();
        test_staging();
        test_locked_write();
        test_timeout();
        test_bad_key2();
        test_relock();
        test_back_to_back();
        test_reset_commit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
